// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off events to a bank of soundproc voices.
// Free voices are taken directly; retrigger, releasing-reuse and steal go
// through a short gate-low gap so the envelope always sees a clean rising edge.

// Per-voice state: FREE/ACTIVE/RELEASING, gate, note, release counter, LRU rank.
module voice_slot #(
  parameter int FREQ_BITS     = 4,
  parameter int RANK_W        = 2,
  parameter int CNT_W         = 12,
  parameter int RELEASE_TICKS = 2205,
  parameter int RESET_RANK    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 freeze,
  input  logic                 load_on,
  input  logic                 load_gap,
  input  logic                 fire,
  input  logic                 rel,
  input  logic [FREQ_BITS-1:0] new_note,
  input  logic                 rank_upd,
  input  logic [RANK_W-1:0]    rank_old,
  output logic                 is_free,
  output logic                 is_active,
  output logic                 is_rel,
  output logic                 gate,
  output logic                 gate_nxt,
  output logic [FREQ_BITS-1:0] note,
  output logic [CNT_W-1:0]     cnt,
  output logic [RANK_W-1:0]    rank
);
  localparam logic [1:0] V_FREE = 2'd0;
  localparam logic [1:0] V_ACT  = 2'd1;
  localparam logic [1:0] V_REL  = 2'd2;

  logic [1:0]           st, st_n;
  logic                 gate_n;
  logic [FREQ_BITS-1:0] note_n;
  logic [CNT_W-1:0]     cnt_n;
  logic [RANK_W-1:0]    rank_n;

  assign is_free   = (st == V_FREE);
  assign is_active = (st == V_ACT);
  assign is_rel    = (st == V_REL);
  assign gate_nxt  = gate_n;

  // Next-state: release countdown first, then controller actions override it,
  // so an assignment landing on an expiring voice wins.
  always_comb begin
    st_n   = st;
    gate_n = gate;
    note_n = note;
    cnt_n  = cnt;
    rank_n = rank;
    if (tick && !freeze && st == V_REL) begin
      if (cnt <= CNT_W'(1)) begin
        cnt_n = '0;
        st_n  = V_FREE;
      end else begin
        cnt_n = cnt - CNT_W'(1);
      end
    end
    if (rel) begin
      st_n   = V_REL;
      gate_n = 1'b0;
      cnt_n  = CNT_W'(RELEASE_TICKS);
    end
    if (load_on) begin
      st_n   = V_ACT;
      gate_n = 1'b1;
      note_n = new_note;
    end
    // Gap target keeps its old state (counter frozen) until the gap fires.
    if (load_gap) begin
      gate_n = 1'b0;
      note_n = new_note;
    end
    if (fire) begin
      st_n   = V_ACT;
      gate_n = 1'b1;
    end
    if (rank_upd) begin
      if (load_on || load_gap) rank_n = '0;
      else if (rank < rank_old) rank_n = rank + RANK_W'(1);
    end
  end

  // Voice registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= V_FREE;
      gate <= 1'b0;
      note <= '0;
      cnt  <= '0;
      rank <= RANK_W'(RESET_RANK);
    end else begin
      st   <= st_n;
      gate <= gate_n;
      note <= note_n;
      cnt  <= cnt_n;
      rank <= rank_n;
    end
  end
endmodule

module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int FREQ_BITS     = 4,
  parameter int RELEASE_TICKS = 2205,
  parameter int GAP_TICKS     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_tick,
  input  logic                            evt_valid,
  output logic                            evt_ready,
  input  logic                            evt_on,
  input  logic [FREQ_BITS-1:0]            evt_note,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES*FREQ_BITS-1:0] voice_note,
  output logic [$clog2(NUM_VOICES+1)-1:0] active_count,
  output logic                            evt_drop
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(RELEASE_TICKS+1);
  localparam int AC_W  = $clog2(NUM_VOICES+1);
  localparam int GT_W  = $clog2(GAP_TICKS+1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]           fsm;
  logic                 lat_on;
  logic [FREQ_BITS-1:0] lat_note;
  logic [IDX_W-1:0]     gap_idx;
  logic [GT_W-1:0]      gap_cnt;

  logic [NUM_VOICES-1:0]                is_free, is_active, is_rel, gate_nxt;
  logic [NUM_VOICES-1:0][FREQ_BITS-1:0] note_arr;
  logic [NUM_VOICES-1:0][CNT_W-1:0]     cnt_arr;
  logic [NUM_VOICES-1:0][IDX_W-1:0]     rank_arr;

  logic             match_hit, free_hit, rel_hit, old_hit;
  logic [IDX_W-1:0] match_idx, free_idx, rel_idx, old_idx;
  logic [CNT_W-1:0] best_cnt;
  logic [IDX_W-1:0] best_rank;

  logic             do_direct, do_gap, do_rel, do_drop, assign_now, fire_now;
  logic [IDX_W-1:0] tgt;
  logic [AC_W-1:0]  pop;

  assign evt_ready  = (fsm == S_IDLE);
  assign voice_note = note_arr;
  assign fire_now   = (fsm == S_GAP) && sample_tick && (gap_cnt == GT_W'(GAP_TICKS-1));
  assign assign_now = do_direct || do_gap;

  // Candidate search over registered voice state, lowest index first.
  always_comb begin
    match_hit = 1'b0; match_idx = '0;
    free_hit  = 1'b0; free_idx  = '0;
    rel_hit   = 1'b0; rel_idx   = '0; best_cnt  = '0;
    old_hit   = 1'b0; old_idx   = '0; best_rank = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && is_active[i] && note_arr[i] == lat_note) begin
        match_hit = 1'b1; match_idx = IDX_W'(i);
      end
      if (!free_hit && is_free[i]) begin
        free_hit = 1'b1; free_idx = IDX_W'(i);
      end
      if (is_rel[i] && (!rel_hit || cnt_arr[i] < best_cnt)) begin
        rel_hit = 1'b1; rel_idx = IDX_W'(i); best_cnt = cnt_arr[i];
      end
      if (is_active[i] && (!old_hit || rank_arr[i] > best_rank)) begin
        old_hit = 1'b1; old_idx = IDX_W'(i); best_rank = rank_arr[i];
      end
    end
  end

  // LOOKUP decision: note-off release/drop, or note-on priority chain.
  always_comb begin
    do_direct = 1'b0;
    do_gap    = 1'b0;
    do_rel    = 1'b0;
    do_drop   = 1'b0;
    tgt       = '0;
    if (fsm == S_LOOKUP) begin
      if (!lat_on) begin
        if (match_hit) begin do_rel = 1'b1; tgt = match_idx; end
        else do_drop = 1'b1;
      end else if (match_hit) begin
        do_gap = 1'b1; tgt = match_idx;
      end else if (free_hit) begin
        do_direct = 1'b1; tgt = free_idx;
      end else if (rel_hit) begin
        do_gap = 1'b1; tgt = rel_idx;
      end else begin
        do_gap = 1'b1; tgt = old_idx;
      end
    end
  end

  // Gate population of the next cycle, so the count lands with the gates.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) pop = pop + AC_W'(gate_nxt[i]);
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    logic hit_tgt, hit_gap;
    assign hit_tgt = (tgt == IDX_W'(g));
    assign hit_gap = (gap_idx == IDX_W'(g));
    voice_slot #(
      .FREQ_BITS    (FREQ_BITS),
      .RANK_W       (IDX_W),
      .CNT_W        (CNT_W),
      .RELEASE_TICKS(RELEASE_TICKS),
      .RESET_RANK   (g)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .tick     (sample_tick),
      .freeze   ((assign_now && hit_tgt) || (fsm == S_GAP && hit_gap)),
      .load_on  (do_direct && hit_tgt),
      .load_gap (do_gap && hit_tgt),
      .fire     (fire_now && hit_gap),
      .rel      (do_rel && hit_tgt),
      .new_note (lat_note),
      .rank_upd (assign_now),
      .rank_old (rank_arr[tgt]),
      .is_free  (is_free[g]),
      .is_active(is_active[g]),
      .is_rel   (is_rel[g]),
      .gate     (voice_gate[g]),
      .gate_nxt (gate_nxt[g]),
      .note     (note_arr[g]),
      .cnt      (cnt_arr[g]),
      .rank     (rank_arr[g])
    );
  end

  // Controller FSM: latch event, decide, optionally wait out the gate gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= S_IDLE;
      lat_on   <= 1'b0;
      lat_note <= '0;
      gap_idx  <= '0;
      gap_cnt  <= '0;
    end else begin
      case (fsm)
        S_IDLE: if (evt_valid) begin
          lat_on   <= evt_on;
          lat_note <= evt_note;
          fsm      <= S_LOOKUP;
        end
        S_LOOKUP: if (do_gap) begin
          fsm     <= S_GAP;
          gap_idx <= tgt;
          gap_cnt <= '0;
        end else begin
          fsm <= S_IDLE;
        end
        S_GAP: if (sample_tick) begin
          if (fire_now) fsm <= S_IDLE;
          else gap_cnt <= gap_cnt + GT_W'(1);
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_drop     <= 1'b0;
      active_count <= '0;
    end else begin
      evt_drop     <= do_drop;
      active_count <= pop;
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed events, an event-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_voice_allocator;
  localparam int NV = 4, FB = 4, RT = 2205, GT = 2;

  logic clk = 1'b0;
  logic rst, sample_tick, evt_valid, evt_on, evt_ready, evt_drop;
  logic [FB-1:0]    evt_note;
  logic [NV-1:0]    voice_gate;
  logic [NV*FB-1:0] voice_note;
  logic [2:0]       active_count;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .FREQ_BITS(FB), .RELEASE_TICKS(RT), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on), .evt_note(evt_note),
    .voice_gate(voice_gate), .voice_note(voice_note),
    .active_count(active_count), .evt_drop(evt_drop)
  );

  int nvec = 0, nerr = 0;
  bit chk_en = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: 0 free, 1 active, 2 releasing; age queue newest first.
  int mst[NV], mnote[NV], mcnt[NV];
  bit mgate[NV];
  int age[$];
  int mfsm, lnote, gtgt, gticks;
  bit lon, mdrop;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin mst[i] = 0; mnote[i] = 0; mcnt[i] = 0; mgate[i] = 0; end
    age.delete();
    for (int i = 0; i < NV; i++) age.push_back(i);
    mfsm = 0; lnote = 0; gtgt = 0; gticks = 0; lon = 0; mdrop = 0;
  endfunction

  function automatic void touch(int v);
    for (int j = 0; j < age.size(); j++) if (age[j] == v) begin age.delete(j); break; end
    age.push_front(v);
  endfunction

  // kind: 1 direct assign, 2 gap assign, 3 release, 4 drop
  function automatic void model_step(bit vld, bit on, int note, bit tick);
    int tgt = -1, kind = 0, hit = -1;
    bit fire = 0;
    mdrop = 0;
    if (mfsm == 1) begin
      for (int i = 0; i < NV; i++) if (hit < 0 && mst[i] == 1 && mnote[i] == lnote) hit = i;
      if (!lon) begin
        if (hit >= 0) begin tgt = hit; kind = 3; end else kind = 4;
      end else if (hit >= 0) begin
        tgt = hit; kind = 2;
      end else begin
        for (int i = 0; i < NV; i++) if (tgt < 0 && mst[i] == 0) tgt = i;
        if (tgt >= 0) kind = 1;
        else begin
          for (int i = 0; i < NV; i++) if (mst[i] == 2 && (tgt < 0 || mcnt[i] < mcnt[tgt])) tgt = i;
          for (int j = age.size() - 1; j >= 0; j--) if (tgt < 0 && mst[age[j]] == 1) tgt = age[j];
          kind = 2;
        end
      end
    end
    if (mfsm == 2 && tick) begin gticks++; fire = (gticks == GT); end
    if (tick)
      for (int i = 0; i < NV; i++)
        if (mst[i] == 2 && !(mfsm == 2 && i == gtgt) && !((kind == 1 || kind == 2) && i == tgt)) begin
          mcnt[i]--;
          if (mcnt[i] == 0) mst[i] = 0;
        end
    case (mfsm)
      0: if (vld) begin lon = on; lnote = note; mfsm = 1; end
      1: begin
        mfsm = 0;
        case (kind)
          1: begin mnote[tgt] = lnote; mgate[tgt] = 1; mst[tgt] = 1; touch(tgt); end
          2: begin mnote[tgt] = lnote; mgate[tgt] = 0; touch(tgt); gtgt = tgt; gticks = 0; mfsm = 2; end
          3: begin mst[tgt] = 2; mgate[tgt] = 0; mcnt[tgt] = RT; end
          default: mdrop = 1;
        endcase
      end
      default: if (fire) begin mgate[gtgt] = 1; mst[gtgt] = 1; mfsm = 0; end
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(evt_valid, evt_on, int'(evt_note), sample_tick);
    end
  end

  // Per-cycle comparison against the model.
  logic [NV-1:0]    eg;
  logic [NV*FB-1:0] en;
  int               ec;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      eg = '0; en = '0; ec = 0;
      for (int i = 0; i < NV; i++) begin
        eg[i] = mgate[i];
        en[i*FB +: FB] = FB'(mnote[i]);
        ec += int'(mgate[i]);
      end
      chk("m_gate", voice_gate, eg);
      chk("m_note", voice_note, en);
      chk("m_count", active_count, ec);
      chk("m_drop", evt_drop, mdrop);
      chk("m_ready", evt_ready, mfsm == 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of the LOOKUP cycle.
  task automatic send(bit on, int note);
    int n = 0;
    while (!evt_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_wait", evt_ready, 1);
    evt_valid = 1; evt_on = on; evt_note = FB'(note);
    @(negedge clk);
    evt_valid = 0;
  endtask

  task automatic tick();
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
  endtask

  initial begin
    rst = 0; sample_tick = 0; evt_valid = 0; evt_on = 0; evt_note = '0;
    #2 rst = 1;
    @(negedge clk);
    chk("rst_gate", voice_gate, 0);
    chk("rst_note", voice_note, 0);
    chk("rst_count", active_count, 0);
    chk("rst_ready", evt_ready, 1);
    chk("rst_drop", evt_drop, 0);
    @(negedge clk);
    rst = 0; chk_en = 1;

    // Fill the bank: each gate rises two cycles after its handshake.
    for (int n = 1; n <= 4; n++) begin
      send(1, n);
      chk("fill_gate_k1", voice_gate[n-1], 0);
      @(negedge clk);
      chk("fill_gate_k2", voice_gate[n-1], 1);
    end
    chk("fill_notes", voice_note, 16'h4321);
    chk("fill_count", active_count, 4);

    // Steal the oldest (voice 0) with note 9.
    send(1, 9);
    chk("steal_ready_k1", evt_ready, 0);
    @(negedge clk);
    chk("steal_gate_k2", voice_gate, 4'hE);
    chk("steal_note_k2", voice_note, 16'h4329);
    tick();
    chk("steal_gate_t1", voice_gate, 4'hE);
    chk("steal_ready_t1", evt_ready, 0);
    @(negedge clk);
    tick();
    chk("steal_gate_t2", voice_gate, 4'hF);
    chk("steal_ready_t2", evt_ready, 1);

    // Retrigger on an idle bank; a tick during LOOKUP is not counted.
    rst = 1; @(negedge clk); rst = 0;
    send(1, 5); @(negedge clk);
    chk("retrig_first", voice_gate, 4'h1);
    send(1, 5);
    tick();
    chk("retrig_k2", voice_gate, 4'h0);
    tick();
    chk("retrig_t1", voice_gate, 4'h0);
    tick();
    chk("retrig_t2", voice_gate, 4'h1);
    chk("retrig_note", voice_note, 16'h0005);

    // Note-off then full release: voice 0 becomes the lowest free voice again.
    send(0, 5); @(negedge clk);
    chk("off_gate", voice_gate, 4'h0);
    for (int t = 0; t < RT; t++) begin tick(); @(negedge clk); end
    send(1, 6); @(negedge clk);
    chk("reuse_gate", voice_gate, 4'h1);
    chk("reuse_note", voice_note, 16'h0006);

    // Releasing-voice reuse picks the smallest counter.
    for (int n = 0; n < 3; n++) begin send(1, (n == 2) ? 10 : 7 + n); @(negedge clk); end
    send(0, 8); @(negedge clk);
    tick(); tick(); tick();
    send(0, 7); @(negedge clk);
    send(1, 11); @(negedge clk);
    chk("rel_reuse_k2", voice_gate, 4'b1001);
    tick(); tick();
    chk("rel_reuse_gate", voice_gate, 4'b1101);
    chk("rel_reuse_note", voice_note, 16'hAB76);

    // Note-off with no ACTIVE match (voice 1 is releasing).
    send(0, 7);
    chk("drop_k1", evt_drop, 0);
    @(negedge clk);
    chk("drop_k2", evt_drop, 1);
    @(negedge clk);
    chk("drop_k3", evt_drop, 0);
    chk("drop_note", voice_note, 16'hAB76);

    // Reset in the middle of a retrigger gap.
    send(1, 6); @(negedge clk);
    chk("gap_gate", voice_gate, 4'b1100);
    @(posedge clk); #2 rst = 1; #1;
    chk("mid_rst_gate", voice_gate, 0);
    chk("mid_rst_note", voice_note, 0);
    chk("mid_rst_count", active_count, 0);
    chk("mid_rst_ready", evt_ready, 1);
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("post_rst_ready", evt_ready, 1);
    send(1, 3); @(negedge clk);
    chk("post_rst_gate", voice_gate, 4'h1);
    chk("post_rst_note", voice_note, 16'h0003);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice controller for the synth. It accepts note-on and note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES soundproc instances by driving that voice's tone_freq_bin and hold (gate). When no voice is free, it reuses a releasing voice or steals the oldest playing one. It sits between the ui_in/uio_in event decoder and the per-voice soundproc instances, and it guarantees every new gate is a clean low-to-high edge seen by the envelope on sample_clk.

## Interface
- NUM_VOICES, 4: number of soundproc voices managed (2..8).
- FREQ_BITS, 4: note code width, same as soundproc tone_freq_bin.
- RELEASE_TICKS, 2205: sample ticks a voice stays RELEASING after gate falls (50 ms at 44.1 kHz); counter width is $clog2(RELEASE_TICKS+1).
- GAP_TICKS, 2: sample ticks gate is held low before a retrigger or steal re-raises it.

Ports:
- clk  in  1  system clock (main_clk domain).
- rst  in  1  reset. Asynchronous and active-high.
- sample_tick  in  1  one-clk pulse per sample_clk rising edge, synchronized upstream.
- evt_valid  in  1  event present.
- evt_ready  out  1  allocator can accept an event.
- evt_on  in  1  1 = note-on, 0 = note-off.
- evt_note  in  FREQ_BITS  note code.
- voice_gate  out  NUM_VOICES  per-voice hold to soundproc.
- voice_note  out  NUM_VOICES*FREQ_BITS  per-voice tone_freq_bin; voice i occupies bits [i*FREQ_BITS +: FREQ_BITS].
- active_count  out  $clog2(NUM_VOICES+1)  number of set bits in voice_gate, registered.
- evt_drop  out  1  one-cycle pulse when a note-off matches no ACTIVE voice.

## Operation
Each voice has a registered per-voice state, either FREE, ACTIVE or RELEASING:
- Gate is 1 only in ACTIVE.
- Each voice also has a release counter and an LRU age rank (0 = newest, NUM_VOICES-1 = oldest). Ranks are always a permutation.

Controller FSM states are IDLE, LOOKUP and GAP.
- IDLE:
  - evt_ready = 1.
  - A handshake (evt_valid && evt_ready) latches evt_on and evt_note, then goes to LOOKUP.
- LOOKUP:
  - evt_ready = 0.
  - Selection is made on registered voice state. Action is taken at the end of the cycle.
- Note-off:
  - Find the lowest-index ACTIVE voice whose note equals the latched note.
  - Set its gate to 0, its state to RELEASING and its counter to RELEASE_TICKS. Go to IDLE.
  - No match: pulse evt_drop and go to IDLE. Voices are unchanged.
- Note-on priority (first rule that matches wins):
  1. ACTIVE voice with an equal note: retrigger that voice through GAP.
  2. Lowest-index FREE voice: set note, gate 1, state ACTIVE. Go to IDLE.
  3. RELEASING voice with the smallest counter (tie goes to the lowest index): assign through GAP.
  4. ACTIVE voice with the highest rank: steal through GAP.
- GAP path:
  - At the end of LOOKUP: gate 0, note loaded, target index latched.
  - Wait for GAP_TICKS sample_tick pulses. The tick counter counts only ticks that occur while in GAP.
  - On the edge of the final tick: gate 1, state ACTIVE. Go to IDLE.
  - The target's release counter is frozen while in GAP.
- LRU update on every assignment (all four rules): the target's rank becomes 0; every voice whose rank is below the target's old rank increments.
- Release timer:
  - On each sample_tick, every RELEASING voice outside GAP decrements its counter.
  - A decrement that reaches 0 sets the voice to FREE.
- Simultaneous events: an assignment at the same edge as a release expiry of the same voice resolves to the assignment.

## Timing
- Reset (asynchronous): FSM = IDLE, evt_ready = 1, all voices FREE, voice_gate = 0, voice_note = 0, counters = 0, rank[i] = i, active_count = 0, evt_drop = 0.
- A reset during LOOKUP or GAP aborts the event; nothing is replayed.
- Direct path: handshake in cycle k, LOOKUP in k+1, voice outputs updated and evt_ready = 1 in k+2.
- Note-off has the same two-cycle latency. evt_drop is high in cycle k+2 only.
- GAP path: gate falls in k+2. Gate rises in the cycle after the GAP_TICKS-th sample_tick counted from k+2 onward.
- evt_ready stays 0 from k+1 until the FSM returns to IDLE. There is at most one event in flight.
- active_count updates in the same cycle as voice_gate.

## Test plan
- Reset, then note-on notes 1,2,3,4 back-to-back: each voice_gate bit rises two cycles after its handshake. Voices 0..3 hold notes 1..4, active_count = 4, ranks = 3,2,1,0.
- All four active, note-on 9: voice 0 (oldest) gate drops in k+2. It rises one cycle after the 2nd subsequent sample_tick with note 9. evt_ready is low throughout.
- Note-on 5 on an idle bank, then note-on 5 again: the same voice retriggers through GAP and no other voice changes.
- Note-off 5: gate falls at k+2. After 2205 sample_ticks the voice is FREE, and the next note-on picks it as the lowest free voice with a direct two-cycle assign.
- Note-off 7 with no matching voice: evt_drop is high for exactly one cycle and voice outputs are unchanged.
- rst asserted mid-GAP: all outputs return to their reset values immediately, and evt_ready = 1 after deassertion.
